// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row synchronisation, press/release
// debounce and hex key code output for a seven-segment decoder.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic [PW-1:0] presc;
  logic          sample_c;
  state_t        state;
  state_t        state_nxt;
  logic [1:0]    col_idx;
  logic [1:0]    col_idx_nxt;
  logic [1:0]    cand_row;
  logic [1:0]    cand_row_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    key_code_nxt;
  logic          key_valid_nxt;
  logic          key_held_nxt;
  logic          any_low_c;
  logic [1:0]    win_row_c;
  logic          cand_high_c;

  // Hex code for a (row, column) position on the keypad.
  function automatic logic [3:0] map_code(input logic [1:0] r, input logic [1:0] c);
    map_code = 4'h0;
    case ({r, c})
      4'b00_00: map_code = 4'h1;
      4'b00_01: map_code = 4'h2;
      4'b00_10: map_code = 4'h3;
      4'b00_11: map_code = 4'hA;
      4'b01_00: map_code = 4'h4;
      4'b01_01: map_code = 4'h5;
      4'b01_10: map_code = 4'h6;
      4'b01_11: map_code = 4'hB;
      4'b10_00: map_code = 4'h7;
      4'b10_01: map_code = 4'h8;
      4'b10_10: map_code = 4'h9;
      4'b10_11: map_code = 4'hC;
      4'b11_00: map_code = 4'hE;
      4'b11_01: map_code = 4'h0;
      4'b11_10: map_code = 4'hF;
      4'b11_11: map_code = 4'hD;
      default:  map_code = 4'h0;
    endcase
  endfunction

  // Two-flop synchroniser for the asynchronous row inputs (idle = pulled up).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
    end
  end

  // Column dwell prescaler; its terminal count is the row sample point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (sample_c) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign sample_c = (presc == PW'(SCAN_DIV - 1));

  // Lowest-index low row wins when several rows are pressed together.
  always_comb begin
    any_low_c = ~&row_sync;
    win_row_c = 2'd3;
    if (!row_sync[0]) begin
      win_row_c = 2'd0;
    end else if (!row_sync[1]) begin
      win_row_c = 2'd1;
    end else if (!row_sync[2]) begin
      win_row_c = 2'd2;
    end
  end

  assign cand_high_c = row_sync[cand_row];
  assign cnt_inc     = cnt + CW'(1);

  // Next-state and next-output logic; every transition waits for a sample point.
  always_comb begin
    state_nxt     = state;
    col_idx_nxt   = col_idx;
    cand_row_nxt  = cand_row;
    cnt_nxt       = cnt;
    key_code_nxt  = key_code;
    key_valid_nxt = 1'b0;
    key_held_nxt  = key_held;
    if (sample_c) begin
      case (state)
        SCAN: begin
          if (any_low_c) begin
            cand_row_nxt = win_row_c;
            cnt_nxt      = CW'(1);
            if (DEBOUNCE_CNT <= 1) begin
              key_code_nxt  = map_code(win_row_c, col_idx);
              key_valid_nxt = 1'b1;
              key_held_nxt  = 1'b1;
              state_nxt     = HELD;
            end else begin
              state_nxt = DEBOUNCE;
            end
          end else begin
            col_idx_nxt = col_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (any_low_c && (win_row_c == cand_row)) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == CW'(DEBOUNCE_CNT)) begin
              key_code_nxt  = map_code(cand_row, col_idx);
              key_valid_nxt = 1'b1;
              key_held_nxt  = 1'b1;
              state_nxt     = HELD;
            end
          end else begin
            cnt_nxt     = '0;
            col_idx_nxt = col_idx + 2'd1;
            state_nxt   = SCAN;
          end
        end
        HELD: begin
          if (cand_high_c) begin
            cnt_nxt = CW'(1);
            if (DEBOUNCE_CNT <= 1) begin
              key_held_nxt = 1'b0;
              cnt_nxt      = '0;
              col_idx_nxt  = col_idx + 2'd1;
              state_nxt    = SCAN;
            end else begin
              state_nxt = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (cand_high_c) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == CW'(DEBOUNCE_CNT)) begin
              key_held_nxt = 1'b0;
              cnt_nxt      = '0;
              col_idx_nxt  = col_idx + 2'd1;
              state_nxt    = SCAN;
            end
          end else begin
            cnt_nxt   = '0;
            state_nxt = HELD;
          end
        end
        default: begin
          state_nxt = SCAN;
        end
      endcase
    end
  end

  // State and registered outputs; column drive is decoded from the next index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      cand_row  <= 2'd0;
      cnt       <= '0;
      col_out   <= 4'b1110;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nxt;
      col_idx   <= col_idx_nxt;
      cand_row  <= cand_row_nxt;
      cnt       <= cnt_nxt;
      col_out   <= ~(4'b0001 << col_idx_nxt);
      key_code  <= key_code_nxt;
      key_valid <= key_valid_nxt;
      key_held  <= key_held_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural keypad matrix.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DC = 3;

  typedef struct {
    int         row;
    int         col;
    logic [3:0] code;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] pressed;
  int          cyc;
  int          nassert = 0;
  int          nfail = 0;
  int          vq[$];
  logic        prev_valid = 1'b0;
  logic [3:0]  exp_code;
  vec_t        tbl[16];

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_in = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (pressed[rr*4+cc] && !col_out[cc]) row_in[rr] = 1'b0;
  end

  // Cycle count since reset release; cyc % SD tracks the dwell phase.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nassert++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Record every key_valid pulse and reject back-to-back pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_valid) begin
        vq.push_back(cyc);
        chk("valid_not_consecutive", 32'(prev_valid), 32'(0));
      end
      prev_valid = key_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  function automatic logic [3:0] key_val(input int r, input int c);
    if (c == 3) return 4'(10 + r);
    if (r == 3) return (c == 0) ? 4'd14 : ((c == 1) ? 4'd0 : 4'd15);
    return 4'(r * 3 + c + 1);
  endfunction

  function automatic logic [3:0] col_pat(input int c);
    logic [3:0] v;
    v = 4'hF;
    v[c] = 1'b0;
    return v;
  endfunction

  // Advance to just after the next sample edge (start of a new dwell).
  task automatic next_slot();
    do begin
      @(posedge clk);
      #1;
    end while (cyc % SD != 0);
  endtask

  task automatic wait_col(input logic [3:0] want);
    int k;
    k = 0;
    next_slot();
    while (col_out !== want && k < 40) begin
      next_slot();
      k++;
    end
    chk("wait_col", 32'(col_out), 32'(want));
  endtask

  // Press key (r,c), optionally with an extra key, for n samples, then release.
  task automatic press_trial(input int r, input int c, input int n, input int extra, input string tag);
    int         er, p, n0;
    bit         acc;
    logic [3:0] prev, exp_k, cexp, cnext;
    acc = (n >= DC);
    er = r;
    if (extra >= 0 && extra % 4 == c && extra / 4 < r) er = extra / 4;
    prev  = exp_code;
    exp_k = key_val(er, c);
    cexp  = col_pat(c);
    cnext = col_pat((c + 1) % 4);
    wait_col(cexp);
    n0 = vq.size();
    p  = cyc;
    pressed[r*4+c] = 1'b1;
    if (extra >= 0) pressed[extra] = 1'b1;
    for (int i = 1; i <= n; i++) begin
      next_slot();
      chk({tag, " col_frozen"}, 32'(col_out), 32'(cexp));
      if (i >= DC) begin
        chk({tag, " held"}, 32'(key_held), 32'(1));
        chk({tag, " code"}, 32'(key_code), 32'(exp_k));
      end else begin
        chk({tag, " not_held"}, 32'(key_held), 32'(0));
        chk({tag, " code_kept"}, 32'(key_code), 32'(prev));
      end
    end
    pressed = '0;
    if (acc) begin
      for (int i = 1; i < DC; i++) begin
        next_slot();
        chk({tag, " held_in_release"}, 32'(key_held), 32'(1));
      end
      next_slot();
      chk({tag, " released"}, 32'(key_held), 32'(0));
      chk({tag, " col_resume"}, 32'(col_out), 32'(cnext));
      chk({tag, " code_retained"}, 32'(key_code), 32'(exp_k));
      exp_code = exp_k;
    end else begin
      next_slot();
      chk({tag, " col_resume"}, 32'(col_out), 32'(cnext));
      chk({tag, " no_held"}, 32'(key_held), 32'(0));
      chk({tag, " code_kept"}, 32'(key_code), 32'(prev));
    end
    chk({tag, " pulses"}, 32'(vq.size() - n0), acc ? 32'(1) : 32'(0));
    if (acc && vq.size() > n0)
      chk({tag, " latency"}, 32'(vq[n0]), 32'(p + 3 + (DC - 1) * SD + 1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", nassert);
    $fatal(1);
  end

  initial begin
    int n0, r, c, n, mode, extra;
    tbl[0]  = '{0, 0, 4'h1}; tbl[1]  = '{0, 1, 4'h2};
    tbl[2]  = '{0, 2, 4'h3}; tbl[3]  = '{0, 3, 4'hA};
    tbl[4]  = '{1, 0, 4'h4}; tbl[5]  = '{1, 1, 4'h5};
    tbl[6]  = '{1, 2, 4'h6}; tbl[7]  = '{1, 3, 4'hB};
    tbl[8]  = '{2, 0, 4'h7}; tbl[9]  = '{2, 1, 4'h8};
    tbl[10] = '{2, 2, 4'h9}; tbl[11] = '{2, 3, 4'hC};
    tbl[12] = '{3, 0, 4'hE}; tbl[13] = '{3, 1, 4'h0};
    tbl[14] = '{3, 2, 4'hF}; tbl[15] = '{3, 3, 4'hD};

    // Reset values and idle scan rotation
    rst_n    = 1'b0;
    pressed  = '0;
    exp_code = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst col_out", 32'(col_out), 32'(4'b1110));
    chk("rst key_code", 32'(key_code), 32'(0));
    chk("rst key_valid", 32'(key_valid), 32'(0));
    chk("rst key_held", 32'(key_held), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (24) begin
      @(negedge clk);
      chk("idle_col", 32'(col_out), 32'(col_pat((cyc / SD) % 4)));
    end
    chk("idle_no_valid", 32'(vq.size()), 32'(0));

    // Clean press of '5' held 20 samples
    press_trial(1, 1, 20, -1, "key5");

    // Full key map from the table
    foreach (tbl[i]) begin
      press_trial(tbl[i].row, tbl[i].col, DC, -1, "map");
      chk("map table_code", 32'(key_code), 32'(tbl[i].code));
    end

    // Press bounce: two samples rejected, three accepted
    press_trial(1, 1, 2, -1, "bounce2");
    press_trial(1, 1, 3, -1, "bounce3");

    // Release bounce on 'B'
    wait_col(col_pat(3));
    n0 = vq.size();
    pressed[7] = 1'b1;
    repeat (4) next_slot();
    chk("relb held", 32'(key_held), 32'(1));
    chk("relb code", 32'(key_code), 32'(4'hB));
    pressed[7] = 1'b0;
    repeat (2) next_slot();
    chk("relb mid_held", 32'(key_held), 32'(1));
    pressed[7] = 1'b1;
    repeat (2) next_slot();
    chk("relb reheld", 32'(key_held), 32'(1));
    chk("relb code_same", 32'(key_code), 32'(4'hB));
    chk("relb col_frozen", 32'(col_out), 32'(col_pat(3)));
    chk("relb one_pulse", 32'(vq.size() - n0), 32'(1));
    pressed = '0;
    repeat (3) next_slot();
    chk("relb released", 32'(key_held), 32'(0));
    chk("relb col_wrap", 32'(col_out), 32'(4'b1110));
    exp_code = 4'hB;

    // Priority: rows 0 and 2 in column 0
    press_trial(0, 0, 4, 8, "prio");
    chk("prio code_1", 32'(key_code), 32'(4'h1));

    // Randomised presses against the key/debounce model
    for (int t = 0; t < 40; t++) begin
      r    = int'($urandom_range(0, 3));
      c    = int'($urandom_range(0, 3));
      n    = int'($urandom_range(1, 6));
      mode = int'($urandom_range(0, 2));
      if (mode == 1)      extra = int'($urandom_range(0, 3)) * 4 + c;
      else if (mode == 2) extra = r * 4 + (c + 1 + int'($urandom_range(0, 2))) % 4;
      else                extra = -1;
      press_trial(r, c, n, extra, "rand");
    end

    // Reset during debounce of '9'
    wait_col(col_pat(2));
    pressed[10] = 1'b1;
    repeat (2) next_slot();
    rst_n = 1'b0;
    #1;
    chk("midrst col_out", 32'(col_out), 32'(4'b1110));
    chk("midrst key_code", 32'(key_code), 32'(0));
    chk("midrst key_valid", 32'(key_valid), 32'(0));
    chk("midrst key_held", 32'(key_held), 32'(0));
    pressed  = '0;
    exp_code = 4'h0;
    n0 = vq.size();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst no_pulse", 32'(vq.size() - n0), 32'(0));
    chk("midrst code_zero", 32'(key_code), 32'(0));
    press_trial(2, 2, 3, -1, "nine_again");
    chk("nine code", 32'(key_code), 32'(4'h9));

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad and produces the 4-bit hex key code that drives the seven-segment decoder input.
- Drives one column low at a time and samples the pulled-up rows. Debounces both press and release.
- Emits a one-cycle strobe per accepted press and holds the last code for display.

Parameters:
SCAN_DIV, 1000, clock cycles each column is driven before its rows are sampled; legal minimum 4
DEBOUNCE_CNT, 8, consecutive matching samples required to accept a press or a release; legal minimum 1

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
row_in  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk
col_out  output  4  keypad column drive, active-low, exactly one bit low at all times
key_code  output  4  hex code of last accepted key
key_valid  output  1  one-cycle pulse when a new key is accepted
key_held  output  1  high from acceptance until debounced release

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: col_out=4'b1110, key_code=0, key_valid=0, key_held=0, state=SCAN, prescaler=0, debounce counter=0.
- Row synchronisation: row_in passes through a 2-flop synchroniser. All decisions use the synchronised rows.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - The sample point is the cycle where the prescaler equals SCAN_DIV-1.
  - All state transitions occur only at sample points.
- Key map (row r = row_in bit, col c = col_out bit):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E(*),0,F(#),D
  - Codes: A=10, B=11, C=12, D=13, *=14, #=15.
- SCAN state:
  - If no row is low at the sample point, the active column rotates 1110→1101→1011→0111→1110.
  - If any row is low, latch the candidate column/row and keep the current column driven. Set the debounce counter to 1 and go to DEBOUNCE; if DEBOUNCE_CNT=1, go directly to accept.
  - When several rows are low, the lowest row index wins.
- DEBOUNCE state:
  - At each sample, if exactly the candidate row is the winning low row, increment the counter.
  - When the counter reaches DEBOUNCE_CNT: register key_code, pulse key_valid high for exactly the next cycle, set key_held=1, and go to HELD.
  - On a mismatch (no row low, or a different winner): go to SCAN, rotate column, and leave outputs unchanged.
- HELD state:
  - The column stays frozen.
  - A sample with the candidate row high sets the counter to 1 and moves to RELEASE; if DEBOUNCE_CNT=1, release completes immediately.
- RELEASE state:
  - A high sample increments the counter.
  - A low sample returns to HELD with no new key_valid and no change to key_code.
  - When the counter reaches DEBOUNCE_CNT: key_held=0, go to SCAN, and rotate to the next column.
- Other keys pressed while locked (DEBOUNCE/HELD/RELEASE) on other columns are ignored. No key rollover.
- key_code retains its value after release until the next accepted key.
- key_valid is never asserted for two consecutive cycles.
- Press latency, measured from the first sample that detects the key: (DEBOUNCE_CNT-1)*SCAN_DIV+1 cycles to the key_valid pulse.
- Reset asserted mid-operation immediately returns all outputs and state to reset values. Scanning restarts at column 0 after release.

Test Plan:
(SCAN_DIV=4, DEBOUNCE_CNT=3 in all scenarios)
- Reset and idle scan: hold rst_n low, then release with rows=4'b1111 → all outputs at reset values; col_out cycles 1110,1101,1011,0111,1110 with each value held exactly 4 cycles; key_valid never asserts.
- Clean press of '5' (row1 low while col1 driven), held 20 samples → col_out freezes at 1101; key_code=5; key_valid is a single pulse 9 cycles after the detecting sample; key_held=1. Release rows → key_held=0 after 3 high samples, then scanning resumes at 1011.
- Code map: press '*', '#', 'D', '0' in turn, each with full release → key_code 14, 15, 13, 0 respectively; one key_valid per press.
- Press bounce: row1 low for 2 samples, then high → no key_valid, key_code unchanged, scanning resumes. Repeat with row low for 3 samples → accepted.
- Release bounce and priority: during HELD, row goes high for 2 samples then low → key_held stays 1 and no key_valid. In col0, rows 0 and 2 both low → key_code=1.
- Reset mid-debounce: assert rst_n during DEBOUNCE of '9' → col_out=1110, key_code=0, key_valid=0, key_held=0 immediately, with no pulse after deassertion unless the key is re-detected.
